// File: rtl/mem_bus_responder_if.sv
// ---------------------------------------------------------------------------
// mem_bus_responder_if
//   Request side of the core's memory bus: the address and the two request
//   strobes. The shared tristate data net is not part of this bundle. It
//   stays a plain inout port on the responder so that the responder and the
//   initiator drive and resolve it as one ordinary net.
//
//   Signals
//     address   initiator -> responder   word address (full width)
//     out_en    initiator -> responder   read request
//     write_en  initiator -> responder   write request
//
//   Modports
//     master    exec unit / testbench side (drives the request)
//     slave     memory responder side (samples the request)
// ---------------------------------------------------------------------------
interface mem_bus_responder_if #(
    parameter int ADDR_BITS = 8
);
    logic [ADDR_BITS-1:0] address;
    logic                 out_en;
    logic                 write_en;

    modport master (output address, output out_en, output write_en);
    modport slave  (input  address, input  out_en, input  write_en);
endinterface

// File: rtl/mem_bus_responder.sv
// ---------------------------------------------------------------------------
// mem_bus_responder
//   Memory-side responder for the core's memory bus. After reset it runs a
//   boot-load phase (LOAD). In LOAD a byte stream fills the internal array
//   and the core is held. When the last byte arrives, or when the array is
//   full, it moves to SERVE. In SERVE it answers the exec unit's reads and
//   writes over the shared tristate data net. SERVE is left only by reset.
//
//   Ports
//     clk         system clock, rising edge
//     reset       synchronous, active-high reset
//     bus         request side of the memory bus (address/out_en/write_en)
//     data        shared data net; driven only during a read response
//     load_valid  boot byte valid
//     load_data   boot byte
//     load_last   final boot byte marker (qualified by load_valid)
//     load_ready  responder accepts boot bytes
//     core_hold   keeps the exec unit idle while high
//     load_count  number of boot bytes accepted
//     bus_error   sticky protocol-violation flag
// ---------------------------------------------------------------------------
module mem_bus_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_responder_if.slave   bus,
    inout  wire  [DATA_BITS-1:0] data,
    input  logic                 load_valid,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 core_hold,
    output logic [ADDR_BITS:0]   load_count,
    output logic                 bus_error
);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam int                   DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t               state_q;
    logic [ADDR_BITS-1:0] ptr_q;
    logic [ADDR_BITS:0]   count_q;
    logic                 bus_error_q;
    logic                 drive_en_q;
    logic [DATA_BITS-1:0] rd_q;
    logic [DATA_BITS-1:0] mem_q [DEPTH];

    // Qualified events for this edge. Every one is masked by reset, so that
    // a reset edge neither loads a byte nor touches the array.
    logic load_accept;
    logic rd_req;
    logic wr_req;
    logic wr_data_unknown;

    assign load_accept     = (state_q == ST_LOAD) && load_valid && !reset;
    assign rd_req          = (state_q == ST_SERVE) && bus.out_en && !bus.write_en && !reset;
    assign wr_req          = (state_q == ST_SERVE) && bus.write_en && !reset;
    // This is always 0 in synthesis. It only flags X/Z write data in simulation.
    assign wr_data_unknown = wr_req && $isunknown(data);

    // Control FSM. The state, the load pointer, the counters and the flags
    // all live here.
    // NOTE: sequential state uses non-blocking (<=) assignments only. Every
    // register then updates from the values it had before the edge, so the
    // result does not depend on the order in which the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_LOAD;
            ptr_q       <= '0;
            count_q     <= '0;
            bus_error_q <= 1'b0;
            drive_en_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    drive_en_q <= 1'b0;
                    if (bus.out_en || bus.write_en) begin
                        bus_error_q <= 1'b1;
                    end
                    if (load_accept) begin
                        count_q <= count_q + 1'b1;
                        // The pointer stops at the top entry instead of
                        // wrapping. The FSM leaves LOAD on that same accept.
                        if (ptr_q != LAST_ADDR) begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                        if (load_last || (ptr_q == LAST_ADDR)) begin
                            state_q <= ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    // The response lasts exactly one cycle per sampled read.
                    // Holding out_en high streams one word per cycle.
                    drive_en_q <= rd_req;
                    if ((bus.out_en && bus.write_en) || wr_data_unknown) begin
                        bus_error_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array and read register.
    // NOTE: the storage array and the read register have no reset. The array
    // keeps its contents across reset, and clearing a RAM would need one
    // write port per word.
    always_ff @(posedge clk) begin
        if (load_accept) begin
            mem_q[ptr_q] <= load_data;
        end else if (wr_req) begin
            mem_q[bus.address] <= data;
        end
        if (rd_req) begin
            rd_q <= mem_q[bus.address];
        end
    end

    // The outputs are also forced to their reset values while reset is high,
    // not only after the reset edge.
    assign data       = (drive_en_q && !reset) ? rd_q : 'z;
    assign load_ready = (state_q == ST_LOAD) && !reset;
    assign core_hold  = (state_q == ST_LOAD) || reset;
    assign load_count = reset ? '0 : count_q;
    assign bus_error  = bus_error_q && !reset;

endmodule

// File: tb/tb_mem_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_responder
//   Directed bench for mem_bus_responder. A table of per-cycle vectors
//   covers boot load, read, write and the read+write collision. Hand-written
//   sequences cover the full-array load and reset during a load. To check
//   that the responder is not driving the data net, the bench drives a
//   probe value onto the net. If the responder also drives, the value read
//   back is disturbed.
// ---------------------------------------------------------------------------
module tb_mem_bus_responder;

    logic       clk;
    logic       reset;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       core_hold;
    logic [8:0] load_count;
    logic       bus_error;
    logic       tb_drv;
    logic [7:0] tb_data;
    wire  [7:0] data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_responder_if #(.ADDR_BITS(8)) bus ();

    assign data = tb_drv ? tb_data : 'z;

    mem_bus_responder #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .data       (data),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .core_hold  (core_hold),
        .load_count (load_count),
        .bus_error  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       lv;
        logic [7:0] ld;
        logic       ll;
        logic       oe;
        logic       we;
        logic [7:0] addr;
        logic       tdrv;
        logic [7:0] tdat;
        logic       e_ready;
        logic       e_hold;
        logic [8:0] e_cnt;
        logic       e_err;
        logic       e_drv;   // responder expected to drive the net
        logic [7:0] e_data;  // expected net value at the check
    } vec_t;

    function automatic vec_t mk(
        input string name, input logic rst, input logic lv, input logic [7:0] ld,
        input logic ll, input logic oe, input logic we, input logic [7:0] addr,
        input logic tdrv, input logic [7:0] tdat, input logic e_ready,
        input logic e_hold, input logic [8:0] e_cnt, input logic e_err,
        input logic e_drv, input logic [7:0] e_data);
        vec_t v;
        v.name = name; v.rst = rst; v.lv = lv; v.ld = ld; v.ll = ll;
        v.oe = oe; v.we = we; v.addr = addr; v.tdrv = tdrv; v.tdat = tdat;
        v.e_ready = e_ready; v.e_hold = e_hold; v.e_cnt = e_cnt;
        v.e_err = e_err; v.e_drv = e_drv; v.e_data = e_data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one vector across one rising edge, then check the outputs just
    // after that edge.
    task automatic step(input vec_t v);
        reset       = v.rst;
        load_valid  = v.lv;
        load_data   = v.ld;
        load_last   = v.ll;
        bus.out_en  = v.oe;
        bus.write_en = v.we;
        bus.address = v.addr;
        tb_drv      = v.tdrv;
        tb_data     = v.tdat;
        @(posedge clk);
        #1;
        if (v.e_drv) begin
            tb_drv = 1'b0;
        end else if (!v.tdrv) begin
            tb_drv  = 1'b1;     // probe: the net must show exactly 00
            tb_data = 8'h00;
        end
        #1;
        check({v.name, ".load_ready"}, 32'(load_ready), 32'(v.e_ready));
        check({v.name, ".core_hold"},  32'(core_hold),  32'(v.e_hold));
        check({v.name, ".load_count"}, 32'(load_count), 32'(v.e_cnt));
        check({v.name, ".bus_error"},  32'(bus_error),  32'(v.e_err));
        check({v.name, ".data"},       32'(data),       32'(v.e_data));
    endtask

    vec_t tbl [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        //                 name         rst lv ld     ll oe we addr   td tdat   rdy hld cnt     err drv data
        tbl[0]  = mk("reset",       1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 9'd0, 0, 0, 8'h00);
        tbl[1]  = mk("load10",      0, 1, 8'h10, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd1, 0, 0, 8'h00);
        tbl[2]  = mk("load20",      0, 1, 8'h20, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd2, 0, 0, 8'h00);
        tbl[3]  = mk("load30last",  0, 1, 8'h30, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd3, 0, 0, 8'h00);
        tbl[4]  = mk("rd1",         0, 1, 8'h99, 0, 1, 0, 8'h01, 0, 8'h00, 0, 0, 9'd3, 0, 1, 8'h20);
        tbl[5]  = mk("rd1_off",     0, 0, 8'h00, 0, 0, 0, 8'h01, 0, 8'h00, 0, 0, 9'd3, 0, 0, 8'h00);
        tbl[6]  = mk("wr40",        0, 0, 8'h00, 0, 0, 1, 8'h40, 1, 8'hA5, 0, 0, 9'd3, 0, 0, 8'hA5);
        tbl[7]  = mk("rd40",        0, 0, 8'h00, 0, 1, 0, 8'h40, 0, 8'h00, 0, 0, 9'd3, 0, 1, 8'hA5);
        tbl[8]  = mk("rd0_b2b",     0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 9'd3, 0, 1, 8'h10);
        tbl[9]  = mk("rd2_b2b",     0, 0, 8'h00, 0, 1, 0, 8'h02, 0, 8'h00, 0, 0, 9'd3, 0, 1, 8'h30);
        tbl[10] = mk("rdwr2",       0, 0, 8'h00, 0, 1, 1, 8'h02, 1, 8'h77, 0, 0, 9'd3, 1, 0, 8'h77);
        tbl[11] = mk("rd2_new",     0, 0, 8'h00, 0, 1, 0, 8'h02, 0, 8'h00, 0, 0, 9'd3, 1, 1, 8'h77);
        tbl[12] = mk("idle_a",      0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd3, 1, 0, 8'h00);
        tbl[13] = mk("idle_b",      0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd3, 1, 0, 8'h00);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i]);
        end

        // Reset during an active read: the net releases while reset is high.
        step(mk("pre_rd",     0, 0, 8'h00, 0, 1, 0, 8'h01, 0, 8'h00, 0, 0, 9'd3, 1, 1, 8'h20));
        step(mk("rst_midrd",  1, 0, 8'h00, 0, 1, 0, 8'h01, 0, 8'h00, 0, 1, 9'd0, 0, 0, 8'h00));
        step(mk("post_rst",   0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd0, 0, 0, 8'h00));

        // Full-array load with no load_last: 256 bytes, value = index.
        for (int i = 0; i < 256; i++) begin
            step(mk($sformatf("full%0d", i), 0, 1, 8'(i), 0, 0, 0, 8'h00, 0, 8'h00,
                    (i < 255), (i < 255), 9'(i + 1), 0, 0, 8'h00));
        end
        step(mk("byte256",    0, 1, 8'hAB, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd256, 0, 0, 8'h00));
        step(mk("full_rd00",  0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 9'd256, 0, 1, 8'h00));
        step(mk("full_rd80",  0, 0, 8'h00, 0, 1, 0, 8'h80, 0, 8'h00, 0, 0, 9'd256, 0, 1, 8'h80));
        step(mk("full_rdFF",  0, 0, 8'h00, 0, 1, 0, 8'hFF, 0, 8'h00, 0, 0, 9'd256, 0, 1, 8'hFF));
        step(mk("full_idle",  0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd256, 0, 0, 8'h00));

        // A bus request during LOAD is an error. Only reset clears it.
        step(mk("r6_rst",     1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 9'd0, 0, 0, 8'h00));
        step(mk("ld_busreq",  0, 0, 8'h00, 0, 1, 0, 8'h05, 0, 8'h00, 1, 1, 9'd0, 1, 0, 8'h00));
        step(mk("ld_errhold", 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd0, 1, 0, 8'h00));
        step(mk("err_rst",    1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 9'd0, 0, 0, 8'h00));

        // Reset after 2 of 4 boot bytes, then reload from address 0.
        step(mk("b01",        0, 1, 8'h01, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd1, 0, 0, 8'h00));
        step(mk("b02",        0, 1, 8'h02, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd2, 0, 0, 8'h00));
        step(mk("b03_rst",    1, 1, 8'h03, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 9'd0, 0, 0, 8'h00));
        step(mk("bEE",        0, 1, 8'hEE, 0, 0, 0, 8'h00, 0, 8'h00, 1, 1, 9'd1, 0, 0, 8'h00));
        step(mk("bFF_last",   0, 1, 8'hFF, 1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd2, 0, 0, 8'h00));
        step(mk("rl_rd0",     0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0, 9'd2, 0, 1, 8'hEE));
        step(mk("rl_rd1",     0, 0, 8'h00, 0, 1, 0, 8'h01, 0, 8'h00, 0, 0, 9'd2, 0, 1, 8'hFF));
        step(mk("rl_rd2",     0, 0, 8'h00, 0, 1, 0, 8'h02, 0, 8'h00, 0, 0, 9'd2, 0, 1, 8'h02));
        step(mk("rl_idle",    0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 9'd2, 0, 0, 8'h00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
